bsg_manycore_inject_arbiter: RTL and testbench
==============================================

BSG_MANYCORE_INJECT_ARBITER -- requirements
Module: bsg_manycore_inject_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of packet requesters (loader, host, etc.), range 2..8.
REQ-002 SHALL have parameter packet_width_p, default 64: width of one manycore packet.
REQ-003 SHALL have parameter max_out_credits_p, default 16: maximum outstanding unacknowledged packets, range 1..255.
REQ-004 SHALL define localparam credit_width_lp = clog2(max_out_credits_p+1).
REQ-005 SHALL have clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have reset_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have req_v_i, input, num_req_p: per-requester packet valid.
REQ-008 SHALL have req_data_i, input, num_req_p*packet_width_p: packets; requester i occupies bits [i*packet_width_p +: packet_width_p].
REQ-009 SHALL have req_lock_i, input, num_req_p: per-requester hold-grant-after-this-packet flag.
REQ-010 SHALL have req_yumi_o, output, num_req_p: one-hot-or-zero packet-accepted strobe.
REQ-011 SHALL have v_o, output, 1: packet valid toward the network.
REQ-012 SHALL have data_o, output, packet_width_p: selected packet.
REQ-013 SHALL have ready_i, input, 1: network accepts packet this cycle.
REQ-014 SHALL have credit_return_i, input, 1: one outstanding packet acknowledged.
REQ-015 SHALL have credits_o, output, credit_width_lp: current credit count.
REQ-016 SHALL have idle_o, output, 1: no outstanding packets and no lock held.

Function
REQ-017 SHALL hold state: round-robin pointer rr_r (0..num_req_p-1), lock_r, lock_owner_r, credit counter credits_r.
REQ-018 SHALL, when lock_r=0, select the first i with req_v_i[i]=1 scanning from rr_r upward with wrap at num_req_p.
REQ-019 SHALL, when lock_r=1, consider only lock_owner_r; other requesters are ignored even if valid.
REQ-020 SHALL drive v_o = selected-requester valid AND credits_r != 0 AND NOT reset_i; v_o SHALL NOT depend combinationally on ready_i.
REQ-021 SHALL drive data_o = req_data_i slice of the selected requester; value is don't-care when v_o=0.
REQ-022 SHALL define transfer = v_o & ready_i; req_yumi_o[sel] = transfer, all other bits 0.
REQ-023 SHALL, on transfer from requester i without lock, set rr_r <= (i+1) mod num_req_p.
REQ-024 SHALL, on transfer with req_lock_i[sel]=1, set lock_r <= 1, lock_owner_r <= sel, and leave rr_r unchanged.
REQ-025 SHALL, on transfer with req_lock_i[sel]=0 while lock_r=1, clear lock_r and set rr_r <= (lock_owner_r+1) mod num_req_p.
REQ-026 SHALL, while locked and owner's req_v_i=0, hold v_o=0 and keep the lock (no grant stealing).
REQ-027 SHALL update credits_r: transfer only -> -1; credit_return_i only -> +1; both same cycle -> unchanged.
REQ-028 SHALL, at credits_r=0, hold v_o=0; a same-cycle credit_return_i takes effect next cycle (no combinational bypass).
REQ-029 SHALL, on credit_return_i with credits_r=max_out_credits_p and no transfer, saturate at max and raise a simulation $error.
REQ-030 SHALL drive credits_o = credits_r and idle_o = (credits_r==max_out_credits_p) & ~lock_r.
REQ-031 SHALL transfer at most one packet per cycle; latency request->v_o is 0 cycles when credits and grant allow.

Reset
REQ-032 SHALL, on reset_i assertion (asynchronous, mid-burst included), set rr_r=0, lock_r=0, lock_owner_r=0, credits_r=max_out_credits_p.
REQ-033 SHALL, during reset, drive v_o=0, req_yumi_o=0, credits_o=max_out_credits_p, idle_o=1.
REQ-034 SHALL, after reset release, arbitrate from requester 0 on the first clock edge.

Verification
REQ-035 Round-robin: num_req_p=2, both valid continuously, ready_i=1, no lock -> grants 0,1,0,1; credits 16->12 after 4 cycles.
REQ-036 Lock burst: req0 sends 3 packets lock=1,1,0 while req1 valid -> req0,req0,req0 then req1; req1 never yumi'd during lock.
REQ-037 Credit stall: max_out_credits_p=2, no returns -> 2 transfers then v_o=0; credit_return_i pulse -> v_o=1 next cycle, credits 0->1.
REQ-038 Simultaneous: transfer and credit_return_i same cycle at credits=5 -> credits stays 5.
REQ-039 Backpressure: ready_i=0 for 3 cycles with req1 valid -> v_o=1 held, data_o stable, req_yumi_o=0, credits unchanged.
REQ-040 Reset mid-lock: assert reset_i asynchronously while lock_r=1, credits=3 -> immediately v_o=0, credits_o=16, idle_o=1; first grant after release goes to req0.

Source files
------------

// File: rtl/bsg_manycore_inject_arbiter.sv
// bsg_manycore_inject_arbiter: round-robin packet injector with lock bursts and credit flow control
// Ports: clk_i/reset_i (async active-high reset), req_v_i/req_data_i/req_lock_i/req_yumi_o requester side,
// v_o/data_o/ready_i network side, credit_return_i/credits_o credit tracking, idle_o quiescent flag.
module bsg_manycore_inject_arbiter #(
  parameter int num_req_p = 2,
  parameter int packet_width_p = 64,
  parameter int max_out_credits_p = 16,
  localparam int credit_width_lp = $clog2(max_out_credits_p+1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*packet_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]                req_lock_i,
  output logic [num_req_p-1:0]                req_yumi_o,
  output logic                                v_o,
  output logic [packet_width_p-1:0]           data_o,
  input  logic                                ready_i,
  input  logic                                credit_return_i,
  output logic [credit_width_lp-1:0]          credits_o,
  output logic                                idle_o
);
  localparam int sw_lp = $clog2(num_req_p);
  localparam logic [sw_lp:0] n_lp = (sw_lp+1)'(num_req_p);
  localparam logic [sw_lp-1:0] last_lp = sw_lp'(num_req_p-1);
  localparam logic [credit_width_lp-1:0] max_lp = credit_width_lp'(max_out_credits_p);
  logic [sw_lp-1:0] rr_r, lock_owner_r, w_off, w_scan, w_sel, w_next;
  logic [sw_lp:0] w_sum;
  logic [num_req_p-1:0] w_rot;
  logic lock_r, w_any, w_selv, w_xfer;
  logic [credit_width_lp-1:0] credits_r;
  // rotate valids so bit 0 is the requester at rr_r; lowest set bit is the round-robin winner
  assign w_rot = num_req_p'({req_v_i, req_v_i} >> rr_r);
  always_comb begin
    w_off = '0;
    w_any = 1'b0;
    for (int k = num_req_p-1; k >= 0; k--)
      if (w_rot[k]) begin
        w_off = sw_lp'(k);
        w_any = 1'b1;
      end
  end
  assign w_sum = {1'b0, rr_r} + {1'b0, w_off};
  assign w_scan = (w_sum >= n_lp) ? sw_lp'(w_sum - n_lp) : w_sum[sw_lp-1:0];
  // a held lock pins the grant to its owner even when the owner is idle
  assign w_sel = lock_r ? lock_owner_r : w_scan;
  assign w_selv = lock_r ? req_v_i[lock_owner_r] : w_any;
  assign v_o = w_selv & (credits_r != '0) & ~reset_i;
  assign w_xfer = v_o & ready_i;
  assign data_o = req_data_i[w_sel*packet_width_p +: packet_width_p];
  assign req_yumi_o = w_xfer ? (num_req_p'(1) << w_sel) : '0;
  assign w_next = (w_sel == last_lp) ? '0 : w_sel + 1'b1;
  assign credits_o = credits_r;
  assign idle_o = (credits_r == max_lp) & ~lock_r;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_r <= '0;
      lock_r <= 1'b0;
      lock_owner_r <= '0;
      credits_r <= max_lp;
    end else begin
      if (w_xfer) begin
        if (req_lock_i[w_sel]) begin
          lock_r <= 1'b1;
          lock_owner_r <= w_sel;
        end else begin
          lock_r <= 1'b0;
          rr_r <= w_next;
        end
      end
      if (w_xfer & ~credit_return_i)
        credits_r <= credits_r - 1'b1;
      else if (~w_xfer & credit_return_i & (credits_r != max_lp))
        credits_r <= credits_r + 1'b1;
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk_i)
    if (!reset_i && credit_return_i && !w_xfer && credits_r == max_lp)
      $error("bsg_manycore_inject_arbiter: credit return with all credits present");
`endif
endmodule

// File: tb/tb_bsg_manycore_inject_arbiter.sv
// tb_bsg_manycore_inject_arbiter: directed and random checks against a behavioural arbiter model
module tb_bsg_manycore_inject_arbiter;
  localparam int N = 3, W = 16, M = 16, CW = $clog2(M+1);
  logic clk = 1'b0, reset_i, v_o, ready_i, credit_return_i, idle_o;
  logic [N-1:0] req_v_i, req_lock_i, req_yumi_o;
  logic [N*W-1:0] req_data_i;
  logic [W-1:0] data_o;
  logic [CW-1:0] credits_o;
  int n_chk = 0, n_pass = 0;
  int m_rr, m_own, m_cred, es;
  bit m_lock, ev, hold;
  logic [N-1:0] o_yumi;
  logic o_v;
  logic [W-1:0] o_data, d0;
  logic [N-1:0] rr_exp [4];
  bsg_manycore_inject_arbiter #(.num_req_p(N), .packet_width_p(W), .max_out_credits_p(M)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_data_i(req_data_i),
    .req_lock_i(req_lock_i), .req_yumi_o(req_yumi_o), .v_o(v_o), .data_o(data_o),
    .ready_i(ready_i), .credit_return_i(credit_return_i), .credits_o(credits_o), .idle_o(idle_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_reset();
    m_rr = 0;
    m_own = 0;
    m_lock = 0;
    m_cred = M;
  endtask
  task automatic predict();
    ev = 0;
    es = 0;
    if (m_lock) begin
      es = m_own;
      ev = req_v_i[m_own];
    end else
      for (int k = 0; k < N; k++) begin
        int i = (m_rr + k) % N;
        if (!ev && req_v_i[i]) begin
          es = i;
          ev = 1;
        end
      end
    ev = ev && (m_cred > 0);
  endtask
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] lk, input logic rdy, input logic ret);
    logic [N-1:0] ey;
    bit x;
    req_v_i = v;
    req_lock_i = lk;
    ready_i = rdy;
    credit_return_i = ret;
    if (!hold) for (int i = 0; i < N; i++) req_data_i[i*W +: W] = W'($urandom);
    #2;
    predict();
    x = ev && rdy;
    ey = x ? (N'(1) << es) : '0;
    o_v = v_o;
    o_yumi = req_yumi_o;
    o_data = data_o;
    chk("v_o", v_o, ev);
    chk("yumi", req_yumi_o, ey);
    if (ev) chk("data", data_o, req_data_i[es*W +: W]);
    chk("credits", credits_o, m_cred);
    chk("idle", idle_o, m_cred == M && !m_lock);
    @(posedge clk);
    if (x) begin
      if (lk[es]) begin
        m_lock = 1;
        m_own = es;
      end else begin
        m_lock = 0;
        m_rr = (es + 1) % N;
      end
    end
    m_cred = m_cred - (x ? 1 : 0) + (ret ? 1 : 0);
    #1;
  endtask
  initial begin
    rr_exp = '{3'b100, 3'b001, 3'b010, 3'b100};
    hold = 0;
    reset_i = 1;
    req_v_i = '1;
    req_lock_i = '0;
    ready_i = 1;
    credit_return_i = 0;
    req_data_i = {3{W'($urandom)}};
    model_reset();
    #2;
    chk("rst_v", v_o, 0);
    chk("rst_yumi", req_yumi_o, 0);
    chk("rst_cred", credits_o, M);
    chk("rst_idle", idle_o, 1);
    @(posedge clk);
    #1;
    reset_i = 0;
    step(3'b011, 3'b001, 1, 0); chk("lk_g0", o_yumi, 3'b001);
    step(3'b011, 3'b001, 1, 0); chk("lk_g1", o_yumi, 3'b001);
    step(3'b011, 3'b000, 1, 0); chk("lk_g2", o_yumi, 3'b001);
    step(3'b011, 3'b000, 1, 0); chk("lk_rel", o_yumi, 3'b010);
    for (int i = 0; i < 4; i++) begin
      step(3'b111, 3'b000, 1, 0);
      chk("rr_grant", o_yumi, rr_exp[i]);
    end
    chk("rr_cred", credits_o, 8);
    step(3'b010, 3'b000, 0, 0);
    d0 = o_data;
    chk("bp_v", o_v, 1);
    hold = 1;
    for (int i = 0; i < 2; i++) begin
      step(3'b010, 3'b000, 0, 0);
      chk("bp_v", o_v, 1);
      chk("bp_data", o_data, d0);
      chk("bp_yumi", o_yumi, 0);
    end
    hold = 0;
    chk("bp_cred", credits_o, 8);
    step(3'b010, 3'b000, 1, 0);
    step(3'b001, 3'b000, 1, 0);
    step(3'b001, 3'b000, 1, 0);
    chk("sim_pre", credits_o, 5);
    step(3'b001, 3'b000, 1, 1);
    chk("sim_cred", credits_o, 5);
    repeat (5) step(3'b001, 3'b000, 1, 0);
    chk("stall_cred", credits_o, 0);
    step(3'b001, 3'b000, 1, 0); chk("stall_v", o_v, 0);
    step(3'b001, 3'b000, 1, 1); chk("ret_same_v", o_v, 0);
    chk("ret_cred", credits_o, 1);
    step(3'b001, 3'b000, 0, 0); chk("ret_v", o_v, 1);
    repeat (3) step(3'b000, 3'b000, 0, 1);
    step(3'b001, 3'b001, 1, 0);
    chk("ml_cred", credits_o, 3);
    chk("ml_idle", idle_o, 0);
    req_v_i = 3'b011;
    ready_i = 1;
    credit_return_i = 0;
    #2;
    reset_i = 1;
    #1;
    chk("ml_rst_v", v_o, 0);
    chk("ml_rst_yumi", req_yumi_o, 0);
    chk("ml_rst_cred", credits_o, M);
    chk("ml_rst_idle", idle_o, 1);
    model_reset();
    @(posedge clk);
    #1;
    reset_i = 0;
    step(3'b011, 3'b000, 1, 0); chk("post_rst", o_yumi, 3'b001);
    repeat (1500) begin
      logic [N-1:0] v, lk;
      logic rdy, ret;
      v = N'($urandom);
      lk = N'($urandom & $urandom);
      rdy = $urandom_range(0, 3) != 0;
      ret = (m_cred < M) && ($urandom_range(0, 1) == 0);
      step(v, lk, rdy, ret);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
